// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the "111" pattern-count datapath.
//   W_DEF, CNT_W_DEF : default frame width and count width
//   top_state_t      : transmitter states (IDLE, SHIFT)
//   match_state_t    : serial matcher states; M0/M1/M2 give the number of
//                      consecutive 1s held in the current candidate
//   PAT_111          : the pattern being counted
// -----------------------------------------------------------------------------
package pattern_pkg;

   localparam int W_DEF     = 32;
   localparam int CNT_W_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } top_state_t;

   typedef enum logic [1:0] {
      M0 = 2'd0,
      M1 = 2'd1,
      M2 = 2'd2
   } match_state_t;

   localparam logic [2:0] PAT_111 = 3'b111;

endpackage

// File: rtl/pat111_serial_match.sv
// -----------------------------------------------------------------------------
// pat111_serial_match
// Counts non-overlapping "111" runs in a serial bit stream, greedy from the
// first bit seen. A completed match consumes its three bits.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   clr     in   clears match state and count (start of a new frame)
//   bit_en  in   bit_in is a completed beat this cycle
//   bit_in  in   serial bit
//   count   out  running match count (CNT_W bits)
// -----------------------------------------------------------------------------
module pat111_serial_match
   import pattern_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             bit_en,
   input  logic             bit_in,
   output logic [CNT_W-1:0] count
);

   match_state_t     st;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       window;
   logic             hit;

   // Thermometer view of the candidate (ones seen so far) plus the new bit;
   // it equals the pattern only when two 1s are pending and a third arrives.
   assign window = {st == M2, st != M0, bit_in};
   assign hit    = (window == PAT_111);
   assign count  = cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st    <= M0;
         cnt_q <= '0;
      end else if (clr) begin
         st    <= M0;
         cnt_q <= '0;
      end else if (bit_en) begin
         if (hit) begin
            cnt_q <= cnt_q + 1'b1;
            st    <= M0;
         end else if (bit_in) begin
            st <= (st == M0) ? M1 : M2;
         end else begin
            st <= M0;
         end
      end
   end

endmodule

// File: rtl/serial_tx_111_count.sv
// -----------------------------------------------------------------------------
// serial_tx_111_count
// Frame transmitter: accepts a W-bit word on a valid/ready handshake, shifts
// it out MSB first one bit per beat, and reports the number of
// non-overlapping "111" matches in the frame one cycle after the last beat.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   in_data valid
//   in_ready  out  can accept a frame
//   in_data   in   W-bit frame
//   tx_ready  in   sink ready (only when TX_READY_EN is defined)
//   tx_valid  out  tx_bit valid
//   tx_bit    out  serial data, MSB first
//   tx_last   out  final bit of the frame
//   done      out  one-cycle pulse, count valid
//   count     out  matches in the last frame, held until the next done
//   busy      out  frame in progress
// Build option: define TX_READY_EN to add sink back-pressure via tx_ready.
// -----------------------------------------------------------------------------
module serial_tx_111_count
   import pattern_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
`ifdef TX_READY_EN
   input  logic             tx_ready,
`endif
   output logic             tx_valid,
   output logic             tx_bit,
   output logic             tx_last,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             busy
);

   localparam int IDX_W = $clog2(W);

   top_state_t       state;
   logic [W-1:0]     shreg;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] count_hold;
   logic [CNT_W-1:0] run_cnt;
   logic             accept;
   logic             beat;

`ifdef TX_READY_EN
   assign beat = tx_valid && tx_ready;
`else
   assign beat = tx_valid;
`endif

   assign accept = in_valid && in_ready;
   assign tx_bit = shreg[W-1];

   // The matcher already holds the final count in the done cycle; the held
   // copy takes over afterwards so a back-to-back frame clearing the matcher
   // does not disturb the reported value.
   assign count = done ? run_cnt : count_hold;

   pat111_serial_match #(
      .CNT_W (CNT_W)
   ) u_match (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .bit_en (beat),
      .bit_in (tx_bit),
      .count  (run_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         idx        <= '0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         tx_valid   <= 1'b0;
         tx_last    <= 1'b0;
         done       <= 1'b0;
         count_hold <= '0;
      end else begin
         done <= 1'b0;
         if (done) begin
            count_hold <= run_cnt;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg    <= in_data;
                  idx      <= IDX_W'(W - 1);
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  tx_valid <= 1'b1;
                  tx_last  <= 1'b0;
               end
            end
            SHIFT: begin
               if (beat) begin
                  shreg   <= {shreg[W-2:0], 1'b0};
                  idx     <= idx - 1'b1;
                  // tx_last is registered one beat ahead of index zero
                  tx_last <= (idx == IDX_W'(1));
                  if (tx_last) begin
                     state    <= IDLE;
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_111_count.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_111_count
// Self-checking bench for serial_tx_111_count: a frame-level reference model
// (greedy scan over the captured word, beat position within the frame) is
// compared against every DUT output each cycle, plus directed frames with
// literal expected counts and randomized frames.
// -----------------------------------------------------------------------------
module tb_serial_tx_111_count;

   localparam int W     = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             tx_valid;
   logic             tx_bit;
   logic             tx_last;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             tx_ready = 1'b1;
   int               ready_mode = 0;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   serial_tx_111_count #(
      .W     (W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
`ifdef TX_READY_EN
      .tx_ready (tx_ready),
`endif
      .tx_valid (tx_valid),
      .tx_bit   (tx_bit),
      .tx_last  (tx_last),
      .done     (done),
      .count    (count),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // sink readiness: alternate every cycle, or random
   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) tx_ready = ~tx_ready;
      else                 tx_ready = 1'($urandom_range(0, 1));
   end

   // Greedy MSB-first scan for non-overlapping 111
   function automatic int greedy(input logic [W-1:0] w);
      int c = 0;
      int i = W - 1;
      while (i >= 2) begin
         if (w[i] && w[i-1] && w[i-2]) begin
            c++;
            i -= 3;
         end else begin
            i--;
         end
      end
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   logic         m_busy  = 1'b0;
   logic         m_done  = 1'b0;
   int           m_count = 0;
   int           m_beat  = 0;
   logic [W-1:0] m_word  = '0;
   logic         m_rdy;

`ifdef TX_READY_EN
   assign m_rdy = tx_ready;
`else
   assign m_rdy = 1'b1;
`endif

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_count <= 0;
         m_beat  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_rdy) begin
               if (m_beat == W - 1) begin
                  m_busy  <= 1'b0;
                  m_done  <= 1'b1;
                  m_count <= greedy(m_word);
               end else begin
                  m_beat <= m_beat + 1;
               end
            end
         end else if (in_valid) begin
            m_word <= in_data;
            m_busy <= 1'b1;
            m_beat <= 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(!m_busy));
         chk("busy",     32'(busy),     32'(m_busy));
         chk("tx_valid", 32'(tx_valid), 32'(m_busy));
         chk("tx_bit",   32'(tx_bit),   m_busy ? 32'(m_word[W-1-m_beat]) : 32'd0);
         chk("tx_last",  32'(tx_last),  32'(m_busy && (m_beat == W - 1)));
         chk("done",     32'(done),     32'(m_done));
         chk("count",    32'(count),    32'(m_count));
      end
   end

   task automatic send(input logic [W-1:0] w);
      int n = 0;
      while (!in_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout at %0t: in_ready %0b required 1", $time, in_ready);
      end
      in_data  = w;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic wait_done(input string nm, input int exp);
      bit seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            chk(nm, 32'(count), 32'(exp));
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout at %0t: done %0b required 1", nm, $time, done);
      end
   endtask

   initial begin
      logic [W-1:0] w;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_count",    32'(count),    32'd0);
      rst_n = 1'b1;

      // pin the reference scan itself
      chk("model_ones",  32'(greedy(32'hFFFFFFFF)), 32'd10);
      chk("model_zero",  32'(greedy(32'h00000000)), 32'd0);
      chk("model_7s",    32'(greedy(32'h77777777)), 32'd8);
      chk("model_0F",    32'(greedy(32'h0000000F)), 32'd1);
      chk("model_E001",  32'(greedy(32'hE0000001)), 32'd1);

      // directed frames (tx_ready alternates when back-pressure is built in)
      send(32'hFFFFFFFF);
      wait_done("all_ones", 10);
      send(32'h00000000);
      wait_done("all_zero", 0);
      send(32'h77777777);
      wait_done("sevens", 8);
      send(32'h0000000F);
      wait_done("tail_1111", 1);
      send(32'hE0000001);          // presented in the done cycle
      wait_done("back_to_back", 1);

      // abandon a frame at beat 10
      send(32'hFFFFFFFF);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_count",    32'(count),    32'd0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("midrst_no_done", 32'(done), 32'd0);
      end

      // randomized frames, idle gaps, random sink readiness
      ready_mode = 1;
      for (int f = 0; f < 25; f++) begin
         w = W'($urandom);
         if (f % 3 == 0) w = w | W'($urandom) | W'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(w);
         wait_done("random", greedy(w));
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_tx_111_count.md
Name: serial_tx_111_count

Overview:
- Frame transmitter. Accepts a W-bit word on a valid/ready handshake and shifts it out serially, MSB first, one bit per cycle.
- While shifting, it counts non-overlapping "111" occurrences in the transmitted stream and reports the count at frame end.
- Matching is greedy from the MSB, so a matched run consumes its three bits before the next match can start.
- Acts as the sending end of the pattern-count datapath: the far end can check its word-level count against this count.

Parameters:
- W, 32, frame width in bits; must be at least 3.
- CNT_W, 4, count width; must be at least $clog2(W/3+1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a frame.
- in_data  input  W  frame to transmit.
- tx_valid  output  1  tx_bit is valid this cycle.
- tx_bit  output  1  serial data, MSB first.
- tx_last  output  1  marks the final bit of the frame.
- done  output  1  one-cycle pulse; count is valid.
- count  output  CNT_W  number of non-overlapping "111" matches in the last frame.
- busy  output  1  frame is in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: in_ready=1, tx_valid=0, tx_bit=0, tx_last=0, done=0, count=0, busy=0. Shift register, bit index and match state all clear.
- Top FSM states: IDLE and SHIFT.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, capture in_data into the shift register, set bit index=W-1, clear match state to M0, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1, tx_valid=1, tx_bit=shreg[W-1].
  - Each beat: shift left by 1, decrement index, advance the match FSM on tx_bit.
  - tx_last=1 when index==0. After that beat, go to IDLE.
- Latency: first bit appears the cycle after acceptance. The frame occupies exactly W consecutive beats.
- Match FSM (M0/M1/M2 = number of consecutive 1s in the current candidate):
  - bit=0: go to M0.
  - bit=1 from M0: go to M1. From M1: go to M2.
  - bit=1 from M2: match; increment the running count; go to M0. Bits are consumed, so there is no overlap.
  - Result equals greedy MSB-first non-overlapping matching over the word.
- Count: the running count is CNT_W bits wide and clears at frame acceptance. Maximum value is floor(W/3) (10 for W=32); it cannot overflow given the CNT_W rule.
- Frame end:
  - In the cycle after the tx_last beat: done=1 for one cycle, count is updated to the final value, in_ready=1.
  - A new frame can be accepted in that same cycle, so throughput is one frame per W+1 cycles.
  - count holds its value until the next done.
- Match state and running count do not carry across frames.
- in_data or in_valid changing while busy is ignored.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values on the next edge. No done is issued.

Optional Feature:
- Macro: TX_READY_EN.
- Defined:
  - Adds input tx_ready (1 bit).
  - A beat completes only when tx_valid&&tx_ready.
  - While tx_ready=0: tx_bit, tx_last and all state hold.
  - The match FSM advances only on completed beats.
  - done fires the cycle after the tx_last beat completes.
- Undefined: no tx_ready port. The sink is assumed always ready, and one beat completes per SHIFT cycle.

Decomposition:
- Shared package pattern_pkg holds:
  - default W and CNT_W localparams;
  - top state enum (IDLE, SHIFT);
  - match state enum (M0, M1, M2);
  - pattern constant PAT_111=3'b111.
- One sub-module, pat111_serial_match:
  - ports: clk, rst_n, clr, bit_en, bit_in, count;
  - contains the M0..M2 FSM and the count register.
  - The top module owns the handshake, the shift register and done/count output.

Test Plan:
- in_data=32'hFFFFFFFF: 32 beats all 1; tx_last on beat 32; then done=1 with count=10.
- in_data=32'h00000000: 32 zero beats; done with count=0.
- in_data=32'h77777777: MSB-first stream 0111×8; count=8.
- in_data=32'h0000000F (ends in 1111) gives count=1. Then 32'hE0000001 accepted back-to-back in the done cycle gives count=1, with no carry-over from the previous frame.
- Reset mid-frame: rst_n=0 at beat 10, frame 32'hFFFFFFFF. Next cycle tx_valid=0, in_ready=1, count=0, and no done pulse.
- TX_READY_EN: frame 32'hFFFFFFFF with tx_ready toggling every other cycle. tx_bit holds while stalled; 32 completed beats; count=10; done one cycle after the final accepted beat.
